io_port_ctrl: RTL

//  Memory-mapped I/O responder on the data-memory bus of the 16-bit MIPS core.

---
 rtl/io_map_pkg.sv | 29 ++
 rtl/sw_debounce.sv | 31 +++
 rtl/io_port_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - io_port_ctrl register map, address decode and segment constants
package io_map_pkg;

  localparam logic [15:0] ADDR_SW    = 16'hfff0;
  localparam logic [15:0] ADDR_DISP0 = 16'hfffa;
  localparam logic [15:0] ADDR_DISP1 = 16'hfffc;
  localparam logic [15:0] ADDR_CTRL  = 16'hfffe;
  localparam logic [11:0] IO_BASE    = 12'hfff;
  localparam logic [6:0]  SEG_OFF    = 7'h7f;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SW,
    SEL_DISP0,
    SEL_DISP1,
    SEL_CTRL
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [15:0] a);
    case (a)
      ADDR_SW:    return SEL_SW;
      ADDR_DISP0: return SEL_DISP0;
      ADDR_DISP1: return SEL_DISP1;
      ADDR_CTRL:  return SEL_CTRL;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch debouncer, used only when IO_DEBOUNCE_EN is defined
module sw_debounce #(
  parameter int DEB_CYCLES = 65535
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count consecutive clocks that disagree with the accepted value; any agreement restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped switch/7-segment responder for the data bus
// Optional switch debouncing is built when IO_DEBOUNCE_EN is defined.
module io_port_ctrl
  import io_map_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEB_CYCLES  = 65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [1:0]  sw,
  output logic        io_sel,
  output logic [15:0] rdata,
  output logic [6:0]  seg_n,
  output logic [1:0]  an_n
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  io_reg_e       sel;
  logic [6:0]    disp0, disp1;
  logic          blank;
  logic [1:0]    sync1, sync2, sw_clean;
  logic [RW-1:0] ref_cnt;
  logic          idx;

  assign sel    = io_decode(addr);
  assign io_sel = (addr[15:4] == IO_BASE);

  always_comb begin
    rdata = 16'h0000;
    if (memread) begin
      case (sel)
        SEL_SW:    rdata = {14'b0, sw_clean};
        SEL_DISP0: rdata = {9'b0, disp0};
        SEL_DISP1: rdata = {9'b0, disp1};
        SEL_CTRL:  rdata = {15'b0, blank};
        default:   rdata = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp0 <= 7'h00;
      disp1 <= 7'h00;
      blank <= 1'b0;
    end else if (memwrite) begin
      case (sel)
        SEL_DISP0: disp0 <= wdata[6:0];
        SEL_DISP1: disp1 <= wdata[6:0];
        SEL_CTRL:  blank <= wdata[0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  for (genvar b = 0; b < 2; b++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (sync2[b]),
      .dout    (sw_clean[b])
    );
  end
`else
  assign sw_clean = sync2;
`endif

  // Outputs sample idx before it toggles, so each digit drives for exactly REFRESH_DIV clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      idx     <= 1'b0;
      seg_n   <= SEG_OFF;
      an_n    <= 2'b11;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= ~idx;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      seg_n <= blank ? SEG_OFF : ~(idx ? disp1 : disp0);
      an_n  <= blank ? 2'b11 : (idx ? 2'b01 : 2'b10);
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wdata[15:7], (DEB_CYCLES == 0)};

endmodule
